// File: rtl/frac_decoder_if.sv
// Character/display bundle for frac_decoder.
// master: upstream character source (also observes the display outputs).
// slave: the decoder itself.
interface frac_decoder_if;
    logic [7:0] fraction_in;
    logic       frac_valid;
    logic       frac_ready;
    logic [9:0] led_out;
    logic [3:0] digit;
    logic       err;
    logic [7:0] err_count;

    modport master (
        output fraction_in, frac_valid,
        input  frac_ready, led_out, digit, err, err_count
    );

    modport slave (
        input  fraction_in, frac_valid,
        output frac_ready, led_out, digit, err, err_count
    );
endinterface

// File: rtl/frac_decoder.sv
// frac_decoder: accepts one ASCII digit per handshake and shows it as a
// thermometer on led_out. After each accepted digit the block refuses input
// for HOLD_CYCLES cycles. Non-digit characters are rejected with a one-cycle
// err pulse.
// Optional build macro FRAC_DECODER_ERRCNT_EN: adds a saturating 8-bit
// rejection counter on err_count; without it err_count is tied to zero.
module frac_decoder #(
    parameter int unsigned PRESET_VAL  = 0,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input logic           clk,
    input logic           rst_n,
    frac_decoder_if.slave bus
);

    // led[k] lit for every k below the digit; bit 9 can never light for 0..9.
    function automatic logic [9:0] therm(input logic [3:0] d);
        logic [9:0] t;
        for (int k = 0; k < 10; k++) begin
            t[k] = (k < 32'(d));
        end
        return t;
    endfunction

    localparam logic [31:0] HoldLoad    = 32'(HOLD_CYCLES - 1);
    localparam logic [3:0]  PresetDigit = 4'(PRESET_VAL);
    localparam logic [9:0]  PresetLed   = therm(PresetDigit);

    typedef enum logic [1:0] {StWake, StIdle, StHold} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_cnt_q;
    logic [3:0]  digit_q;
    logic [9:0]  led_q;
    logic        err_q;
    logic        ready;
    logic        xfer;
    logic        is_digit;

    assign is_digit = (bus.fraction_in >= 8'h30) && (bus.fraction_in <= 8'h39);
    assign xfer     = bus.frac_valid && ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWake;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWake: state_d = StIdle;
            StIdle: if (xfer && is_digit) state_d = StHold;
            StHold: if (hold_cnt_q == 32'd0) state_d = StIdle;
            default: state_d = StWake;
        endcase
    end

    // Outputs decoded from the state register only, so ready is glitch-free.
    always_comb begin
        ready = (state_q == StIdle);
    end

    // Hold counter, digit/display registers and the rejection pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= 32'd0;
            digit_q    <= PresetDigit;
            led_q      <= PresetLed;
            err_q      <= 1'b0;
        end else begin
            err_q <= xfer && !is_digit;
            if (xfer && is_digit) begin
                hold_cnt_q <= HoldLoad;
                // Low nibble of ASCII '0'..'9' is the digit value itself.
                digit_q    <= bus.fraction_in[3:0];
                led_q      <= therm(bus.fraction_in[3:0]);
            end else if (state_q == StHold && hold_cnt_q != 32'd0) begin
                hold_cnt_q <= hold_cnt_q - 32'd1;
            end
        end
    end

`ifdef FRAC_DECODER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of rejected characters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (xfer && !is_digit && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = 8'h00;
`endif

    assign bus.frac_ready = ready;
    assign bus.digit      = digit_q;
    assign bus.led_out    = led_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_frac_decoder.sv
// Self-checking bench for frac_decoder (HOLD_CYCLES=4, PRESET_VAL=0).
// A cycle-level reference model tracks readiness as "cycles of refusal left"
// and the display as plain arithmetic on the accepted character.
module tb_frac_decoder;

    localparam int unsigned HoldCycles = 4;
    localparam int unsigned Preset     = 0;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    frac_decoder_if bus ();

    frac_decoder #(
        .PRESET_VAL (Preset),
        .HOLD_CYCLES(HoldCycles)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    bit m_awake;
    bit m_ready;
    int m_digit;
    bit m_err;
    int m_cnt;
    int m_low_left;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_errcnt_max();
`ifdef FRAC_DECODER_ERRCNT_EN
        return 255;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_awake    = 0;
        m_ready    = 0;
        m_digit    = Preset;
        m_err      = 0;
        m_cnt      = 0;
        m_low_left = 0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_edge();
        bit xfer;
        int c;
        if (!m_awake) begin
            m_awake = 1;
            m_ready = 1;
            m_err   = 0;
            return;
        end
        xfer  = bus.frac_valid && m_ready;
        c     = int'(bus.fraction_in);
        m_err = 0;
        if (m_low_left > 0) m_low_left--;
        if (xfer) begin
            if (c >= 48 && c <= 57) begin
                m_digit    = c - 48;
                m_low_left = HoldCycles;
            end else begin
                m_err = 1;
                if (m_cnt < exp_errcnt_max()) m_cnt++;
            end
        end
        m_ready = (m_low_left == 0);
    endtask

    task automatic check_model();
        check_eq("ready", 32'(bus.frac_ready), 32'(m_ready));
        check_eq("digit", 32'(bus.digit), 32'(m_digit));
        check_eq("led", 32'(bus.led_out), 32'((1 << m_digit) - 1));
        check_eq("err", 32'(bus.err), 32'(m_err));
        check_eq("err_count", 32'(bus.err_count), 32'(m_cnt));
    endtask

    // Advance one clock, update the model, then compare away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must drop immediately.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq({tag, "_ready"}, 32'(bus.frac_ready), 32'd0);
        check_eq({tag, "_digit"}, 32'(bus.digit), 32'(Preset));
        check_eq({tag, "_led"}, 32'(bus.led_out), 32'h000);
        check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
        check_eq({tag, "_cnt"}, 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq({tag, "_ready_rel"}, 32'(bus.frac_ready), 32'd0);
    endtask

    function automatic logic [7:0] rand_nondigit();
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        if (c >= 8'h30 && c <= 8'h39) c = c + 8'h10;
        return c;
    endfunction

    initial begin
        int lows;
        int guard;
        n_tests            = 0;
        n_fail             = 0;
        rst_n              = 1'b0;
        bus.frac_valid     = 1'b0;
        bus.fraction_in    = 8'h00;
        model_reset();

        // Reset values, then first edge after release refuses a transfer.
        #1;
        check_eq("rst_ready", 32'(bus.frac_ready), 32'd0);
        check_eq("rst_digit", 32'(bus.digit), 32'd0);
        check_eq("rst_led", 32'(bus.led_out), 32'h000);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_cnt", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.frac_valid  = 1'b1;
        bus.fraction_in = 8'h37;
        #1;
        check_eq("wake_ready", 32'(bus.frac_ready), 32'd0);
        step();
        check_eq("wake_ready_up", 32'(bus.frac_ready), 32'd1);
        check_eq("wake_no_xfer", 32'(bus.digit), 32'd0);

        // Digit '5', with '9' held valid through the hold window.
        bus.fraction_in = 8'h35;
        step();
        check_eq("d5_digit", 32'(bus.digit), 32'd5);
        check_eq("d5_led", 32'(bus.led_out), 32'h01F);
        bus.fraction_in = 8'h39;
        lows  = 1;
        guard = 0;
        while (!bus.frac_ready && guard < 20) begin
            step();
            if (!bus.frac_ready) lows++;
            guard++;
        end
        check_eq("hold_len", 32'(lows), 32'(HoldCycles));
        check_eq("hold_ignore", 32'(bus.digit), 32'd5);
        bus.fraction_in = 8'h30;
        step();
        check_eq("d0_digit", 32'(bus.digit), 32'd0);
        check_eq("d0_led", 32'(bus.led_out), 32'h000);
        bus.frac_valid = 1'b0;
        repeat (HoldCycles + 1) step();

        // Two consecutive rejections.
        bus.frac_valid  = 1'b1;
        bus.fraction_in = 8'h41;
        step();
        check_eq("rej1_err", 32'(bus.err), 32'd1);
        bus.fraction_in = 8'h2F;
        step();
        check_eq("rej2_err", 32'(bus.err), 32'd1);
        check_eq("rej2_ready", 32'(bus.frac_ready), 32'd1);
        bus.frac_valid = 1'b0;
        step();
        check_eq("rej_err_end", 32'(bus.err), 32'd0);
        check_eq("rej_cnt", 32'(bus.err_count), (exp_errcnt_max() != 0) ? 32'd2 : 32'd0);
        check_eq("rej_led", 32'(bus.led_out), 32'h000);

        // Reset in the middle of a hold.
        bus.frac_valid  = 1'b1;
        bus.fraction_in = 8'h38;
        step();
        bus.frac_valid = 1'b0;
        step();
        step();
        pulse_reset("midhold");
        step();
        check_eq("midhold_idle", 32'(bus.frac_ready), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.frac_valid  = ($urandom_range(0, 3) != 0);
            bus.fraction_in = ($urandom_range(0, 1) != 0) ? 8'(8'h30 + $urandom_range(0, 9))
                                                          : rand_nondigit();
            step();
        end

        // Saturation of the rejection counter.
        pulse_reset("sat");
        step();
        bus.frac_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.fraction_in = rand_nondigit();
            step();
        end
        check_eq("sat_cnt", 32'(bus.err_count), 32'(exp_errcnt_max()));
        repeat (3) step();
        check_eq("sat_hold", 32'(bus.err_count), 32'(exp_errcnt_max()));
        bus.frac_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
